// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A)
// and memory (M) writeback paths. Optional conflict counter: RF_WARB_STATS_EN.
module rf_write_arbiter #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          stall,
   input  logic          req_a,
   input  logic [AW-1:0] reg_a,
   input  logic [DW-1:0] val_a,
   output logic          ack_a,
   input  logic          req_m,
   input  logic [AW-1:0] reg_m,
   input  logic [DW-1:0] val_m,
   output logic          ack_m,
   output logic          RegWrite,
   output logic [AW-1:0] writeReg,
   output logic [DW-1:0] writeValue,
   output logic          busy
`ifdef RF_WARB_STATS_EN
   ,
   output logic [15:0]   conflict_cnt
`endif
);

   // Handshake: a requester holds req/reg/val stable until its ack is 1; the
   // request is consumed at the rising edge where ack=1, and the requester may
   // present a new request (or deassert) in the very next cycle.

   logic          last_q, last_d;           // 0: A won last, 1: M won last
   logic          reg_write_q, reg_write_d;
   logic [AW-1:0] write_reg_q, write_reg_d;
   logic [DW-1:0] write_value_q, write_value_d;
   logic          grant_a, grant_m;

   // Reset forces last=1 so A takes the first contention.
   always_comb begin
      grant_a = 1'b0;
      grant_m = 1'b0;
      if (RST_N && !stall) begin
         if (req_a && req_m) begin
            grant_a = last_q;
            grant_m = ~last_q;
         end else begin
            grant_a = req_a;
            grant_m = req_m;
         end
      end
   end

   always_comb begin
      last_d        = last_q;
      reg_write_d   = 1'b0;
      write_reg_d   = write_reg_q;
      write_value_d = write_value_q;
      if (grant_a) begin
         last_d        = 1'b0;
         write_reg_d   = reg_a;
         write_value_d = val_a;
         reg_write_d   = (reg_a != '0);
      end else if (grant_m) begin
         last_d        = 1'b1;
         write_reg_d   = reg_m;
         write_value_d = val_m;
         reg_write_d   = (reg_m != '0);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_q        <= 1'b1;
         reg_write_q   <= 1'b0;
         write_reg_q   <= '0;
         write_value_q <= '0;
      end else begin
         last_q        <= last_d;
         reg_write_q   <= reg_write_d;
         write_reg_q   <= write_reg_d;
         write_value_q <= write_value_d;
      end
   end

   assign ack_a      = grant_a;
   assign ack_m      = grant_m;
   assign RegWrite   = reg_write_q;
   assign writeReg   = write_reg_q;
   assign writeValue = write_value_q;
   assign busy       = (req_a & ~grant_a) | (req_m & ~grant_m);

`ifdef RF_WARB_STATS_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   // Counts cycles where both sources compete and grants are not stalled.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (req_a && req_m && !stall && (conflict_cnt_q != 16'hFFFF))
         conflict_cnt_d = conflict_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) conflict_cnt_q <= '0;
      else        conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed + random bench for rf_write_arbiter with a write-record scoreboard.
module tb_rf_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        stall = 1'b0;
  logic        req_a = 1'b0, req_m = 1'b0;
  logic [3:0]  reg_a = '0, reg_m = '0;
  logic [15:0] val_a = '0, val_m = '0;
  logic        ack_a, ack_m, RegWrite, busy;
  logic [3:0]  writeReg;
  logic [15:0] writeValue;
`ifdef RF_WARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  rf_write_arbiter #(.DW(16), .AW(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .stall(stall),
    .req_a(req_a), .reg_a(reg_a), .val_a(val_a), .ack_a(ack_a),
    .req_m(req_m), .reg_m(reg_m), .val_m(val_m), .ack_m(ack_m),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeValue(writeValue),
    .busy(busy)
`ifdef RF_WARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  // expected {RegWrite, writeReg, writeValue} after each edge
  logic [20:0] exp_q[$];
  logic        m_last;
  logic [3:0]  m_reg;
  logic [15:0] m_val;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_reg  = '0;
    m_val  = '0;
    m_cnt  = '0;
    exp_q.delete();
  endtask

  // Reset with a pending A request; nothing may be acked or written.
  task automatic do_reset();
    RST_N = 1'b0;
    stall = 1'b0;
    req_a = 1'b1; reg_a = 4'd7; val_a = 16'h7777;
    req_m = 1'b0;
    #1;
    chk("rst_ack_a", ack_a, 1'b0);
    @(posedge CLK); #1;
    chk("rst_ack_a_edge", ack_a, 1'b0);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_writereg", writeReg, 4'd0);
    chk("rst_writevalue", writeValue, 16'h0);
`ifdef RF_WARB_STATS_EN
    chk("rst_conflict_cnt", conflict_cnt, 16'h0);
`endif
    req_a = 1'b0;
    RST_N = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus: check acks/busy mid-cycle, then the registered write.
  task automatic cycle(input logic st,
                       input logic ra, input logic [3:0] rga, input logic [15:0] va,
                       input logic rm, input logic [3:0] rgm, input logic [15:0] vm,
                       output logic ga, output logic gm);
    logic [20:0] e;
    stall = st;
    req_a = ra; reg_a = rga; val_a = va;
    req_m = rm; reg_m = rgm; val_m = vm;
    ga = 1'b0;
    gm = 1'b0;
    if (!st) begin
      if (ra && rm) begin
        if (m_last) ga = 1'b1;
        else        gm = 1'b1;
      end else begin
        ga = ra;
        gm = rm;
      end
    end
    #1;
    chk("ack_a", ack_a, ga);
    chk("ack_m", ack_m, gm);
    chk("busy", busy, (ra && !ga) || (rm && !gm));
    if (ga) begin
      m_reg = rga; m_val = va; m_last = 1'b0;
      exp_q.push_back({(rga != 4'd0), rga, va});
    end else if (gm) begin
      m_reg = rgm; m_val = vm; m_last = 1'b1;
      exp_q.push_back({(rgm != 4'd0), rgm, vm});
    end else begin
      exp_q.push_back({1'b0, m_reg, m_val});
    end
    if (ra && rm && !st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    @(posedge CLK); #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("regwrite", RegWrite, e[20]);
      chk("writereg", writeReg, e[19:16]);
      chk("writevalue", writeValue, e[15:0]);
    end
`ifdef RF_WARB_STATS_EN
    chk("conflict_cnt", conflict_cnt, m_cnt);
`endif
  endtask

  logic        ga, gm;
  logic        pa, pm;
  logic [3:0]  pra, prm;
  logic [15:0] pva, pvm;
  logic        st;

  initial begin
    model_reset();
    do_reset();

    // Contention straight after reset: A, M, A.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 4'd2, 16'h1111, 1'b1, 4'd3, 16'h2222, ga, gm);
      chk("cont_order_a", ga, (i != 1));
    end

    // Single A then idle.
    cycle(1'b0, 1'b1, 4'd1, 16'hABCD, 1'b0, 4'd0, 16'h0, ga, gm);
    chk("single_a_written", {RegWrite, writeReg, writeValue}, {1'b1, 4'd1, 16'hABCD});
    cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, ga, gm);

    // Write to register 0 is acked but never enabled.
    cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h2030, ga, gm);
    chk("reg0_no_write", RegWrite, 1'b0);

    // Stall after a fresh reset, then A wins on release.
    do_reset();
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd6, 16'h6666, ga, gm);
    cycle(1'b0, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd6, 16'h6666, ga, gm);
    chk("release_a_first", writeReg, 4'd4);
    cycle(1'b0, 1'b0, 4'd4, 16'h4444, 1'b1, 4'd6, 16'h6666, ga, gm);

    // Random traffic obeying the hold-until-ack protocol.
    pa = 1'b0; pm = 1'b0;
    pra = '0; prm = '0; pva = '0; pvm = '0;
    for (int i = 0; i < 60; i++) begin
      if (!pa && $urandom_range(0, 1) == 1) begin
        pa = 1'b1; pra = 4'($urandom_range(0, 15)); pva = 16'($urandom_range(0, 65535));
      end
      if (!pm && $urandom_range(0, 1) == 1) begin
        pm = 1'b1; prm = 4'($urandom_range(0, 15)); pvm = 16'($urandom_range(0, 65535));
      end
      st = ($urandom_range(0, 4) == 0);
      cycle(st, pa, pra, pva, pm, prm, pvm, ga, gm);
      if (ga) pa = 1'b0;
      if (gm) pm = 1'b0;
    end

    // Mid-operation reset discards the registered M write.
    cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h5555, ga, gm);
    chk("midop_write_visible", {RegWrite, writeReg, writeValue}, {1'b1, 4'd5, 16'h5555});
    req_m = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("midop_regwrite", RegWrite, 1'b0);
    chk("midop_writereg", writeReg, 4'd0);
    chk("midop_writevalue", writeValue, 16'h0);
`ifdef RF_WARB_STATS_EN
    chk("midop_conflict_cnt", conflict_cnt, 16'h0);
`endif
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, 4'd9, 16'h9999, 1'b1, 4'd8, 16'h8888, ga, gm);
    chk("post_reset_a_first", ga, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, ga, gm);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
